// File: rtl/w_icons_spi_frame_decoder.sv
// SPI byte-stream command decoder: assembles CRC-8 protected read/write frames
// into single-cycle register strobes and feeds read responses back to the shifter.
module w_icons_spi_frame_decoder #(
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cs_n_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic [9:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [15:0] reg_rdata_i,
    input  logic        err_clr_i,
    output logic        err_crc_o,
    output logic [3:0]  dbg_state_o
);

    // Handshake: rx_valid_i is a one-cycle strobe with no back-pressure; every
    // strobe seen while cs_n_i is low is consumed in that same cycle.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_DATA_H = 4'd2,
        S_DATA_L = 4'd3,
        S_CRC    = 4'd4,
        S_RD_H   = 4'd5,
        S_RD_L   = 4'd6,
        S_RD_CRC = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_crc;
    logic        r_is_wr;
    logic [9:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic        r_re;
    logic        r_cap;
    logic [15:0] r_rdata;
    logic [7:0]  r_tx;
    logic        r_err;

    logic        w_we_set;
    logic        w_re_set;
    logic        w_err_set;
    logic [7:0]  w_crc_step;
    logic [7:0]  w_resp_crc;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_crc_step = crc8_byte(r_crc, rx_byte_i);
    assign w_resp_crc = crc8_byte(crc8_byte(CRC_INIT, r_rdata[15:8]), r_rdata[7:0]);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_we_set  = 1'b0;
        w_re_set  = 1'b0;
        w_err_set = 1'b0;
        if (cs_n_i) begin
            w_next = S_IDLE;
        end else if (rx_valid_i) begin
            case (r_state)
                S_IDLE:   w_next = S_ADDR;
                S_ADDR:   w_next = r_is_wr ? S_DATA_H : S_CRC;
                S_DATA_H: w_next = S_DATA_L;
                S_DATA_L: w_next = S_CRC;
                S_CRC: begin
                    if (rx_byte_i == r_crc) begin
                        w_we_set = r_is_wr;
                        w_re_set = !r_is_wr;
                        w_next   = r_is_wr ? S_DONE : S_RD_H;
                    end else begin
                        w_err_set = 1'b1;
                        w_next    = S_DONE;
                    end
                end
                S_RD_H:   w_next = S_RD_L;
                S_RD_L:   w_next = S_RD_CRC;
                S_RD_CRC: w_next = S_DONE;
                S_DONE:   w_next = S_DONE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_crc   <= CRC_INIT;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_cap   <= 1'b0;
            r_rdata <= '0;
            r_tx    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we  <= w_we_set;
            r_re  <= w_re_set;
            // Read data arrives the cycle after the read strobe.
            r_cap <= r_re && !cs_n_i;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
            if (cs_n_i) begin
                r_crc <= CRC_INIT;
                r_tx  <= '0;
            end else begin
                if (r_cap) begin
                    r_rdata <= reg_rdata_i;
                    r_tx    <= reg_rdata_i[15:8];
                end
                if (rx_valid_i) begin
                    case (r_state)
                        S_IDLE: begin
                            r_crc       <= crc8_byte(CRC_INIT, rx_byte_i);
                            r_is_wr     <= rx_byte_i[7];
                            r_addr[9:8] <= rx_byte_i[1:0];
                        end
                        S_ADDR: begin
                            r_crc       <= w_crc_step;
                            r_addr[7:0] <= rx_byte_i;
                        end
                        S_DATA_H: begin
                            r_crc          <= w_crc_step;
                            r_wdata[15:8]  <= rx_byte_i;
                        end
                        S_DATA_L: begin
                            r_crc         <= w_crc_step;
                            r_wdata[7:0]  <= rx_byte_i;
                        end
                        S_RD_H:   r_tx <= r_rdata[7:0];
                        S_RD_L:   r_tx <= w_resp_crc;
                        S_RD_CRC: r_tx <= '0;
                        default:  ;
                    endcase
                end
            end
        end
    end

    assign tx_byte_o   = r_tx;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign reg_re_o    = r_re;
    assign err_crc_o   = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_w_icons_spi_frame_decoder.sv
// Directed bench for the SPI frame decoder: write, read, CRC error, abort and
// reset-mid-frame scenarios with hand-derived expectations.
module tb_w_icons_spi_frame_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic [9:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = 16'hDEAD;
    logic        err_clr;
    logic        err_crc;
    logic [3:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int dbl      = 0;
    logic prev_strobe = 1'b0;
    logic [15:0] rd_value = 16'h1234;
    logic [7:0]  c;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_DONE = 4'd8;

    always #5 clk = ~clk;

    w_icons_spi_frame_decoder dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cs_n_i      (cs_n),
        .rx_byte_i   (rx_byte),
        .rx_valid_i  (rx_valid),
        .tx_byte_o   (tx_byte),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_rdata_i (reg_rdata),
        .err_clr_i   (err_clr),
        .err_crc_o   (err_crc),
        .dbg_state_o (dbg_state)
    );

    // Register file model: data valid only in the cycle after the read strobe.
    always @(posedge clk) reg_rdata <= reg_re ? rd_value : 16'hDEAD;

    always @(negedge clk) begin
        if (reg_we) we_cnt++;
        if (reg_re) re_cnt++;
        if ((reg_we || reg_re) && prev_strobe) dbl++;
        prev_strobe = reg_we || reg_re;
    end

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] x;
        x = crc ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        idle(1);
        cs_n = 1'b0;
        idle(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"},    tx_byte, 8'h00);
        check({tag, "_addr"},  reg_addr, 10'h000);
        check({tag, "_wdata"}, reg_wdata, 16'h0000);
        check({tag, "_we"},    reg_we, 1'b0);
        check({tag, "_re"},    reg_re, 1'b0);
        check({tag, "_err"},   err_crc, 1'b0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        reset_n  = 1'b0;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        err_clr  = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        cs_n    = 1'b0;
        idle(1);

        // Reference CRC model against the published check values.
        c = 8'h00;
        for (int i = 0; i < 9; i++) c = crc8(c, 8'h31 + 8'(i));
        check("crc_model_check", c, 8'hF4);
        check("crc_model_0x80", crc8(8'h00, 8'h80), 8'h89);

        // Valid write frame.
        c = crc8(crc8(crc8(crc8(8'h00, 8'h81), 8'h23), 8'hBE), 8'hEF);
        send(8'h81); idle(1); send(8'h23); idle(1);
        send(8'hBE); idle(1); send(8'hEF); idle(1);
        send(c);
        check("wr_we", reg_we, 1'b1);
        check("wr_addr", reg_addr, 10'h123);
        check("wr_wdata", reg_wdata, 16'hBEEF);
        idle(1);
        check("wr_we_single", reg_we, 1'b0);
        check("wr_err", err_crc, 1'b0);
        check("wr_done", dbg_state, ST_DONE);
        frame_end();

        // Same frame with corrupted CRC, then clear.
        send(8'h81); send(8'h23); send(8'hBE); send(8'hEF);
        send(c ^ 8'h01);
        check("bad_we", reg_we, 1'b0);
        check("bad_err", err_crc, 1'b1);
        check("bad_done", dbg_state, ST_DONE);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("bad_err_clr", err_crc, 1'b0);
        check("bad_we_cnt", we_cnt, 1);
        frame_end();

        // Read frame with response bytes.
        send(8'h02); idle(1); send(8'h10); idle(1);
        send(crc8(crc8(8'h00, 8'h02), 8'h10));
        check("rd_re", reg_re, 1'b1);
        check("rd_addr", reg_addr, 10'h210);
        check("rd_tx_pre", tx_byte, 8'h00);
        idle(1);
        check("rd_re_single", reg_re, 1'b0);
        idle(1);
        check("rd_tx_h", tx_byte, 8'h12);
        idle(3);
        send(8'h00);
        check("rd_tx_l", tx_byte, 8'h34);
        send(8'h00);
        check("rd_tx_crc", tx_byte, crc8(crc8(8'h00, 8'h12), 8'h34));
        send(8'h00);
        check("rd_tx_zero", tx_byte, 8'h00);
        send(8'hAA);
        check("rd_done_tx", tx_byte, 8'h00);
        check("rd_done", dbg_state, ST_DONE);
        frame_end();
        check("rd_re_cnt", re_cnt, 1);

        // Abort after DATA_H; cs_n high together with a byte that must be dropped.
        send(8'h81); send(8'h23); send(8'hBE);
        rx_byte  = 8'h81;
        rx_valid = 1'b1;
        cs_n     = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        check("abort_idle", dbg_state, ST_IDLE);
        cs_n = 1'b0;
        idle(1);
        check("abort_no_we", we_cnt, 1);
        c = crc8(crc8(crc8(crc8(8'h00, 8'h80), 8'h05), 8'h12), 8'h34);
        send(8'h80); send(8'h05); send(8'h12); send(8'h34); send(c);
        check("b2b_we", reg_we, 1'b1);
        check("b2b_addr", reg_addr, 10'h005);
        check("b2b_wdata", reg_wdata, 16'h1234);
        frame_end();

        // Mismatch with simultaneous clear: set wins.
        c = crc8(crc8(crc8(crc8(8'h00, 8'h81), 8'h23), 8'hBE), 8'hEF);
        send(8'h81); send(8'h23); send(8'hBE); send(8'hEF);
        rx_byte  = c ^ 8'hFF;
        rx_valid = 1'b1;
        err_clr  = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        check("setwins_err", err_crc, 1'b1);
        check("setwins_we", reg_we, 1'b0);
        frame_end();

        // Reset pulse coincident with DATA_L.
        send(8'h81); send(8'h23); send(8'hBE);
        rx_byte  = 8'hEF;
        rx_valid = 1'b1;
        reset_n  = 1'b0;
        idle(1);
        rx_valid = 1'b0;
        reset_n  = 1'b1;
        check_reset_values("midrst");
        idle(2);
        check("midrst_no_we", we_cnt, 2);
        send(8'h81); send(8'h23); send(8'hBE); send(8'hEF); send(c);
        check("post_rst_we", reg_we, 1'b1);
        check("post_rst_wdata", reg_wdata, 16'hBEEF);
        frame_end();

        idle(3);
        check("final_we_cnt", we_cnt, 3);
        check("final_re_cnt", re_cnt, 1);
        check("final_no_double", dbl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
